scan_decoder: RTL and testbench
===============================

# scan_decoder

Registered, parametrised binary-to-one-hot decoder with a built-in scan sequencer. It replaces the fixed 2-to-4 combinational decoder wherever the Conway grid needs row/column select lines. It has two uses. In direct mode it decodes a presented index with one-cycle latency. In scan mode it walks the one-hot output across all lines autonomously, for row-by-row grid update and readout.

## Interface
- `SEL_WIDTH`, 2: width of the binary index.
- `NUM_OUT`, 4: number of one-hot lines; legal range 2 .. 2**SEL_WIDTH.
- `DWELL`, 1: cycles each line stays asserted during a scan; must be ≥ 1.

- `clk`  in  1  clock; all state changes on the rising edge.
- `reset_n`  in  1  reset, synchronous, active-low.
- `sel_in`  in  SEL_WIDTH  index for direct decode.
- `sel_valid`  in  1  sample `sel_in` this cycle.
- `start`  in  1  begin a scan from index 0.
- `stop`  in  1  abort a scan in progress.
- `wrap`  in  1  scan restarts at 0 after the last line instead of finishing; sampled every cycle.
- `onehot_out`  out  NUM_OUT  registered one-hot select; all-zero when nothing is selected.
- `index_out`  out  SEL_WIDTH  binary index of the asserted line; 0 when `out_valid`=0.
- `out_valid`  out  1  `onehot_out` holds exactly one asserted bit.
- `busy`  out  1  scan in progress.
- `done`  out  1  one-cycle pulse when a non-wrapping scan completes.
- `sel_err`  out  1  one-cycle pulse when a direct index ≥ NUM_OUT is rejected.

## Operation
- States: IDLE, HOLD, SCAN.
- **Reset** (`reset_n`=0 at the edge):
  - next state IDLE.
  - `onehot_out`=0, `index_out`=0, `out_valid`=0, `busy`=0, `done`=0, `sel_err`=0.
  - dwell counter = 0.
  - Reset overrides every other input, including mid-scan.
- **IDLE / HOLD with `start`=1:**
  - go to SCAN with index 0.
  - Same-cycle `sel_valid` is ignored and does not raise `sel_err`.
- **IDLE / HOLD with `sel_valid`=1, `start`=0:**
  - If `sel_in` < NUM_OUT: go to HOLD; `onehot_out` = 1 << `sel_in`; `index_out` = `sel_in`; `out_valid`=1.
  - Otherwise: go to IDLE; `onehot_out`=0; `out_valid`=0; `sel_err`=1 for one cycle.
- **HOLD:** outputs are held until the next `sel_valid` or `start`. `stop` has no effect in HOLD or IDLE.
- **SCAN:**
  - `busy`=1 and `out_valid`=1 throughout.
  - Each line stays asserted for DWELL cycles.
  - At the end of a dwell, if index < NUM_OUT−1, the index increments.
  - At the end of the dwell on index NUM_OUT−1:
    - `wrap`=1: index returns to 0 and the scan continues.
    - `wrap`=0: go to IDLE; outputs cleared; `busy`=0; `done`=1 for that cycle.
  - `stop`=1 in SCAN: next cycle goes to IDLE with outputs cleared, `busy`=0, and no `done`. `stop` beats the end-of-scan transition in the same cycle.
  - `start` and `sel_valid` are ignored while in SCAN; a scan is never restarted mid-flight.
- **Index arithmetic:**
  - The index counter is SEL_WIDTH bits and never exceeds NUM_OUT−1; wrap is explicit, not modular.
  - The dwell counter is $clog2(DWELL+1) bits and resets to 0 on every index change.

## Timing
- All outputs are registered; no combinational input-to-output path.
- **Direct decode latency:** 1 cycle. `sel_valid` at edge N gives `onehot_out` valid after edge N.
- **Scan:**
  - `start` at edge N: line 0 is asserted from edge N through edge N+DWELL.
  - Line k is asserted during cycles N+k·DWELL .. N+(k+1)·DWELL−1.
  - `done` is high during cycle N+NUM_OUT·DWELL; `busy` is low in that same cycle.
  - Total non-wrapping scan length: NUM_OUT·DWELL cycles of `busy`=1.
- **Back-to-back:** `start` in the cycle that `done` is high is accepted, since the state is IDLE. The new scan begins with no gap cycle.
- **Pulse widths:** `done` and `sel_err` are exactly one cycle and never coincide.

## Test plan
- **Reset, then direct decode.** SEL_WIDTH=2, NUM_OUT=4. Apply `sel_valid` with `sel_in`=0,1,2,3 on consecutive cycles. One cycle later `onehot_out` must read 0001, 0010, 0100, 1000, with matching `index_out` and `out_valid`=1.
- **Out-of-range rejection.** SEL_WIDTH=2, NUM_OUT=3, `sel_in`=3. Next cycle: `onehot_out`=000, `out_valid`=0, `sel_err`=1 for exactly one cycle.
- **Non-wrapping scan.** NUM_OUT=4, DWELL=2, `start` pulse. Each line 0001→0010→0100→1000 is held 2 cycles; `busy` is high for 8 cycles; then `done`=1 for one cycle with `onehot_out`=0.
- **Wrapping scan with stop.** DWELL=1, `wrap`=1. After 0001, 0010, 0100, 1000, the output returns to 0001. Assert `stop` while on 0010: next cycle outputs are 0, `busy`=0, `done` never pulses.
- **Ignored inputs in SCAN.** Assert `sel_valid` and `start` mid-scan: the sequence is undisturbed and no `sel_err`. Assert `start` and `sel_valid` together in IDLE: the scan starts and `sel_err` stays 0.
- **Reset mid-scan.** Drop `reset_n` for one edge during line 2. All outputs go to 0 on that edge; `done` never pulses. After release, a direct `sel_valid` `sel_in`=1 yields 0010.

Source files
------------

// File: rtl/scan_decoder_if.sv
// Select-line bus for scan_decoder: index/scan controls in, one-hot select and status out.
interface scan_decoder_if #(
  parameter int SEL_WIDTH = 2,
  parameter int NUM_OUT   = 4
);
  logic [SEL_WIDTH-1:0] sel_in;
  logic                 sel_valid;
  logic                 start;
  logic                 stop;
  logic                 wrap;
  logic [NUM_OUT-1:0]   onehot_out;
  logic [SEL_WIDTH-1:0] index_out;
  logic                 out_valid;
  logic                 busy;
  logic                 done;
  logic                 sel_err;

  modport master (
    output sel_in, sel_valid, start, stop, wrap,
    input  onehot_out, index_out, out_valid, busy, done, sel_err
  );

  modport slave (
    input  sel_in, sel_valid, start, stop, wrap,
    output onehot_out, index_out, out_valid, busy, done, sel_err
  );
endinterface

// File: rtl/scan_decoder.sv
// Registered binary-to-one-hot decoder with an autonomous line scanner for
// Conway-grid row/column selection.
module scan_decoder #(
  parameter int SEL_WIDTH = 2,
  parameter int NUM_OUT   = 4,
  parameter int DWELL     = 1
) (
  input logic           clk,
  input logic           reset_n,
  scan_decoder_if.slave bus
);
  localparam int CW = $clog2(DWELL + 1);
  localparam logic [SEL_WIDTH:0]   NUM_OUT_W  = (SEL_WIDTH + 1)'(NUM_OUT);
  localparam logic [SEL_WIDTH-1:0] LAST_IDX   = SEL_WIDTH'(NUM_OUT - 1);
  localparam logic [SEL_WIDTH-1:0] IDX_ZERO   = {SEL_WIDTH{1'b0}};
  localparam logic [SEL_WIDTH-1:0] IDX_ONE    = SEL_WIDTH'(1'b1);
  localparam logic [CW-1:0]        DWELL_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0]        CNT_ZERO   = {CW{1'b0}};
  localparam logic [CW-1:0]        CNT_ONE    = CW'(1'b1);
  localparam logic [NUM_OUT-1:0]   OH_ONE     = NUM_OUT'(1'b1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    SCAN = 2'd2
  } state_t;

  state_t               state_r, state_s;
  logic [SEL_WIDTH-1:0] idx_r, idx_s;
  logic [CW-1:0]        dwell_r, dwell_s;
  logic [NUM_OUT-1:0]   onehot_r, onehot_s;
  logic                 valid_r;
  logic                 busy_r;
  logic                 done_r, done_s;
  logic                 sel_err_r, sel_err_s;

  // Next-state, next-index and pulse decode; index is forced to 0 whenever IDLE is entered.
  always_comb begin
    state_s   = state_r;
    idx_s     = idx_r;
    dwell_s   = dwell_r;
    done_s    = 1'b0;
    sel_err_s = 1'b0;
    case (state_r)
      IDLE, HOLD: begin
        if (bus.start) begin
          state_s = SCAN;
          idx_s   = IDX_ZERO;
          dwell_s = CNT_ZERO;
        end else if (bus.sel_valid) begin
          dwell_s = CNT_ZERO;
          if ({1'b0, bus.sel_in} < NUM_OUT_W) begin
            state_s = HOLD;
            idx_s   = bus.sel_in;
          end else begin
            state_s   = IDLE;
            idx_s     = IDX_ZERO;
            sel_err_s = 1'b1;
          end
        end else begin
          state_s = state_r;
        end
      end
      SCAN: begin
        // stop has priority over the end-of-scan decision taken in the same cycle
        if (bus.stop) begin
          state_s = IDLE;
          idx_s   = IDX_ZERO;
          dwell_s = CNT_ZERO;
        end else if (dwell_r == DWELL_LAST) begin
          dwell_s = CNT_ZERO;
          if (idx_r == LAST_IDX) begin
            if (bus.wrap) begin
              idx_s = IDX_ZERO;
            end else begin
              state_s = IDLE;
              idx_s   = IDX_ZERO;
              done_s  = 1'b1;
            end
          end else begin
            idx_s = idx_r + IDX_ONE;
          end
        end else begin
          dwell_s = dwell_r + CNT_ONE;
        end
      end
      default: begin
        state_s = IDLE;
        idx_s   = IDX_ZERO;
        dwell_s = CNT_ZERO;
      end
    endcase
    onehot_s = (state_s == IDLE) ? {NUM_OUT{1'b0}} : (OH_ONE << idx_s);
  end

  // State, counters and all outputs are registered here.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r   <= IDLE;
      idx_r     <= IDX_ZERO;
      dwell_r   <= CNT_ZERO;
      onehot_r  <= {NUM_OUT{1'b0}};
      valid_r   <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      sel_err_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      idx_r     <= idx_s;
      dwell_r   <= dwell_s;
      onehot_r  <= onehot_s;
      valid_r   <= (state_s != IDLE);
      busy_r    <= (state_s == SCAN);
      done_r    <= done_s;
      sel_err_r <= sel_err_s;
    end
  end

  assign bus.onehot_out = onehot_r;
  assign bus.index_out  = idx_r;
  assign bus.out_valid  = valid_r;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.sel_err    = sel_err_r;
endmodule

// File: tb/tb_scan_decoder.sv
// Drives three scan_decoder configurations from shared stimulus and checks them
// every cycle against a cycle-count reference model, plus literal spot checks.
module tb_scan_decoder;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] sel_in = 2'd0;
  logic       sel_valid = 1'b0, start = 1'b0, stop = 1'b0, wrap = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  scan_decoder_if #(.SEL_WIDTH(2), .NUM_OUT(4)) bus_a ();
  scan_decoder_if #(.SEL_WIDTH(2), .NUM_OUT(3)) bus_b ();
  scan_decoder_if #(.SEL_WIDTH(2), .NUM_OUT(4)) bus_c ();

  scan_decoder #(.SEL_WIDTH(2), .NUM_OUT(4), .DWELL(1)) dut_a (.clk(clk), .reset_n(reset_n), .bus(bus_a));
  scan_decoder #(.SEL_WIDTH(2), .NUM_OUT(3), .DWELL(1)) dut_b (.clk(clk), .reset_n(reset_n), .bus(bus_b));
  scan_decoder #(.SEL_WIDTH(2), .NUM_OUT(4), .DWELL(2)) dut_c (.clk(clk), .reset_n(reset_n), .bus(bus_c));

  assign bus_a.sel_in = sel_in;  assign bus_a.sel_valid = sel_valid;  assign bus_a.start = start;
  assign bus_a.stop = stop;      assign bus_a.wrap = wrap;
  assign bus_b.sel_in = sel_in;  assign bus_b.sel_valid = sel_valid;  assign bus_b.start = start;
  assign bus_b.stop = stop;      assign bus_b.wrap = wrap;
  assign bus_c.sel_in = sel_in;  assign bus_c.sel_valid = sel_valid;  assign bus_c.start = start;
  assign bus_c.stop = stop;      assign bus_c.wrap = wrap;

  logic [3:0] oh [3];
  logic [1:0] ix [3];
  logic       vl [3], bz [3], dn [3], er [3];
  assign oh[0] = bus_a.onehot_out;          assign oh[1] = {1'b0, bus_b.onehot_out}; assign oh[2] = bus_c.onehot_out;
  assign ix[0] = bus_a.index_out;           assign ix[1] = bus_b.index_out;          assign ix[2] = bus_c.index_out;
  assign vl[0] = bus_a.out_valid;           assign vl[1] = bus_b.out_valid;          assign vl[2] = bus_c.out_valid;
  assign bz[0] = bus_a.busy;                assign bz[1] = bus_b.busy;               assign bz[2] = bus_c.busy;
  assign dn[0] = bus_a.done;                assign dn[1] = bus_b.done;               assign dn[2] = bus_c.done;
  assign er[0] = bus_a.sel_err;             assign er[1] = bus_b.sel_err;            assign er[2] = bus_c.sel_err;

  // Reference model: mode 0 idle, 1 hold (pos = line), 2 scan (pos = cycles elapsed since start).
  int n_cfg [3] = '{4, 3, 4};
  int d_cfg [3] = '{1, 1, 2};
  int m_mode [3];
  int m_pos [3];
  bit m_done [3], m_err [3];
  bit model_ok = 1'b0;

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!reset_n) begin
        m_mode[i] <= 0; m_pos[i] <= 0; m_done[i] <= 1'b0; m_err[i] <= 1'b0;
      end else begin
        m_done[i] <= 1'b0;
        m_err[i]  <= 1'b0;
        if (m_mode[i] == 2) begin
          if (stop) begin
            m_mode[i] <= 0; m_pos[i] <= 0;
          end else if (m_pos[i] + 1 == n_cfg[i] * d_cfg[i]) begin
            if (wrap) m_pos[i] <= 0;
            else begin m_mode[i] <= 0; m_pos[i] <= 0; m_done[i] <= 1'b1; end
          end else begin
            m_pos[i] <= m_pos[i] + 1;
          end
        end else if (start) begin
          m_mode[i] <= 2; m_pos[i] <= 0;
        end else if (sel_valid) begin
          if (int'(sel_in) < n_cfg[i]) begin m_mode[i] <= 1; m_pos[i] <= int'(sel_in); end
          else begin m_mode[i] <= 0; m_pos[i] <= 0; m_err[i] <= 1'b1; end
        end
      end
    end
    if (!reset_n) model_ok <= 1'b1;
  end

  function automatic int exp_line(int i);
    if (m_mode[i] == 2) return m_pos[i] / d_cfg[i];
    if (m_mode[i] == 1) return m_pos[i];
    return 0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output of every configuration against the model.
  always @(negedge clk) begin
    if (model_ok) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("cfg%0d onehot", i), 32'(oh[i]), (m_mode[i] != 0) ? (32'd1 << exp_line(i)) : 32'd0);
        chk($sformatf("cfg%0d index", i), 32'(ix[i]), 32'(exp_line(i)));
        chk($sformatf("cfg%0d out_valid", i), 32'(vl[i]), 32'(m_mode[i] != 0));
        chk($sformatf("cfg%0d busy", i), 32'(bz[i]), 32'(m_mode[i] == 2));
        chk($sformatf("cfg%0d done", i), 32'(dn[i]), 32'(m_done[i]));
        chk($sformatf("cfg%0d sel_err", i), 32'(er[i]), 32'(m_err[i]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((bz[0] || bz[1] || bz[2]) && k < 40) begin tick(); k++; end
    chk("idle timeout", 32'(k < 40), 32'd1);
  endtask

  initial begin
    logic [3:0] one = 4'b0001;
    int cnt;
    repeat (2) tick();
    chk("reset onehot", 32'(oh[0]), 32'd0);
    chk("reset valid", 32'(vl[0]), 32'd0);
    reset_n = 1'b1;

    // direct decode of every index; cfg1 (3 lines) rejects index 3
    sel_valid = 1'b1;
    for (int s = 0; s < 4; s++) begin
      sel_in = 2'(s);
      tick();
      chk("direct onehot", 32'(oh[0]), 32'(one << s));
      chk("direct index", 32'(ix[0]), 32'(s));
    end
    chk("reject sel_err", 32'(er[1]), 32'd1);
    chk("reject onehot", 32'(oh[1]), 32'd0);
    chk("reject valid", 32'(vl[1]), 32'd0);
    sel_valid = 1'b0;
    tick();
    chk("sel_err one cycle", 32'(er[1]), 32'd0);

    // non-wrapping scan, DWELL=2 on cfg2: 8 busy cycles then done
    start = 1'b1; tick(); start = 1'b0;
    cnt = 0;
    for (int k = 0; k < 20 && !dn[2]; k++) begin
      if (bz[2]) cnt++;
      tick();
    end
    chk("dwell2 busy cycles", 32'(cnt), 32'd8);
    chk("dwell2 done", 32'(dn[2]), 32'd1);
    chk("dwell2 done onehot", 32'(oh[2]), 32'd0);
    tick();

    // wrapping scan with ignored start/sel_valid mid-scan, then stop
    wrap = 1'b1; start = 1'b1; tick(); start = 1'b0;
    for (int j = 0; j < 6; j++) begin
      if (j == 3) begin
        chk("wrap line3", 32'(oh[0]), 32'h8);
        chk("ignored sel_err", 32'(er[1]), 32'd0);
      end
      if (j == 4) chk("wrap back to 0", 32'(oh[0]), 32'h1);
      sel_valid = (j == 2); start = (j == 2); sel_in = 2'd3;
      stop = (j == 5);
      tick();
    end
    stop = 1'b0; wrap = 1'b0;
    chk("stop onehot", 32'(oh[0]), 32'd0);
    chk("stop busy", 32'(bz[0]), 32'd0);
    chk("stop no done", 32'(dn[0]), 32'd0);
    tick();
    chk("stop no done later", 32'(dn[0]), 32'd0);

    // start and sel_valid together in IDLE
    sel_valid = 1'b1; sel_in = 2'd3; start = 1'b1; tick();
    sel_valid = 1'b0; start = 1'b0;
    chk("start wins busy", 32'(bz[0]), 32'd1);
    chk("start wins no err", 32'(er[1]), 32'd0);
    wait_idle();
    tick();

    // reset during line 2
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    chk("pre-reset line2", 32'(oh[0]), 32'h4);
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    chk("mid reset onehot", 32'(oh[0]), 32'd0);
    chk("mid reset busy", 32'(bz[2]), 32'd0);
    sel_valid = 1'b1; sel_in = 2'd1; tick(); sel_valid = 1'b0;
    chk("post reset decode", 32'(oh[0]), 32'h2);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      reset_n   = ($urandom_range(0, 99) != 0);
      sel_valid = ($urandom_range(0, 9) < 3);
      sel_in    = 2'($urandom_range(0, 3));
      start     = ($urandom_range(0, 19) == 0);
      stop      = ($urandom_range(0, 24) == 0);
      wrap      = ($urandom_range(0, 1) == 1);
      tick();
    end
    reset_n = 1'b1; sel_valid = 1'b0; start = 1'b0; stop = 1'b0;
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
